// File: rtl/pico_fifo_pkg.sv
// pico_fifo_pkg: shared width helper and error-flag bit positions for the pico FIFO family
package pico_fifo_pkg;
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W = 2;
  function automatic int clogb2(input int n);
    int r = 0;
    int v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/fifo_level_ctl.sv
// fifo_level_ctl: occupancy, oldest-entry pointer, threshold and sticky error flags
// Error flags are live only when PICO_FIFO_ERR_EN is defined.
module fifo_level_ctl
  import pico_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int LW = clogb2(DEPTH + 1),
  localparam int PW = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             addq,
  input  logic             shiftq,
  input  logic             err_clear,
  output logic             push_en,
  output logic [PW-1:0]    ptr,
  output logic [LW-1:0]    level,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ERR_W-1:0] err
);
  logic pop_en;
  logic [LW-1:0] level_nx;
  logic [PW-1:0] ptr_nx;
  assign push_en = ~flush & addq & (~full | (shiftq & ~empty));
  assign pop_en = ~flush & shiftq & ~empty;
  assign level_nx = flush ? '0 : level + LW'(push_en) - LW'(pop_en);
  // Entries shift up on push, so the oldest moves up unless a pop consumes it too
  assign ptr_nx = flush ? '0
                : (push_en & ~pop_en & ~empty) ? ptr + PW'(1)
                : (pop_en & ~push_en & ptr != '0) ? ptr - PW'(1)
                : ptr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
      ptr <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      almost_empty <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      level <= level_nx;
      ptr <= ptr_nx;
      empty <= level_nx == '0;
      full <= level_nx == LW'(DEPTH);
      almost_empty <= level_nx <= LW'(AEMPTY_THRESH);
      almost_full <= level_nx >= LW'(AFULL_THRESH);
    end
  end
`ifdef PICO_FIFO_ERR_EN
  logic [ERR_W-1:0] err_set;
  always_comb begin
    err_set = '0;
    err_set[ERR_OVF] = addq & full & ~shiftq;
    err_set[ERR_UDF] = shiftq & empty;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err <= '0;
    else err <= err_set | (err & {ERR_W{~err_clear}});
  end
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear;
  assign err = '0;
`endif
endmodule

// File: rtl/fifo_level.sv
// fifo_level: shift-register FIFO with level, threshold flags and optional sticky errors
// Define PICO_FIFO_ERR_EN to enable overflow/underflow reporting.
module fifo_level
  import pico_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AFULL_THRESH = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  localparam int LW = clogb2(DEPTH + 1),
  localparam int PW = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             addq,
  input  logic [WIDTH-1:0] indata,
  input  logic             shiftq,
  output logic [WIDTH-1:0] outdata,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clear
);
  logic push_en;
  logic [PW-1:0] ptr;
  logic [ERR_W-1:0] err;
  logic [WIDTH-1:0] mem [DEPTH];
  fifo_level_ctl #(
    .DEPTH(DEPTH),
    .AFULL_THRESH(AFULL_THRESH),
    .AEMPTY_THRESH(AEMPTY_THRESH)
  ) u_ctl (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .addq(addq),
    .shiftq(shiftq),
    .err_clear(err_clear),
    .push_en(push_en),
    .ptr(ptr),
    .level(level),
    .empty(empty),
    .full(full),
    .almost_empty(almost_empty),
    .almost_full(almost_full),
    .err(err)
  );
  // Storage is deliberately unreset; occupancy alone defines validity
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[0] <= indata;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end
  assign outdata = mem[ptr];
  assign overflow = err[ERR_OVF];
  assign underflow = err[ERR_UDF];
endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: table-driven and directed checks of fifo_level at DEPTH=4, WIDTH=8
module tb_fifo_level;
  logic clk = 0, reset = 0, flush = 0, addq = 0, shiftq = 0, err_clear = 0;
  logic [7:0] indata = 0, outdata;
  logic empty, full, almost_empty, almost_full, overflow, underflow;
  logic [2:0] level;
  int tests = 0, fails = 0;
  logic ovf_on;
  typedef struct {
    logic fl, aq, sq;
    logic [7:0] din;
    int lvl;
    logic e, f, ae, af;
    logic [7:0] dout;
    logic chk;
  } vec_t;
  vec_t v[15];

  fifo_level #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .addq(addq), .indata(indata),
    .shiftq(shiftq), .outdata(outdata), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .level(level),
    .overflow(overflow), .underflow(underflow), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic op(input logic fl, input logic aq, input logic sq, input logic [7:0] d, input logic ec);
    @(negedge clk);
    flush = fl; addq = aq; shiftq = sq; indata = d; err_clear = ec;
    @(posedge clk);
    #1;
  endtask

  task automatic flags(input string nm, input int lvl, input logic e, input logic f, input logic ae, input logic af);
    chk({nm, " level"}, 32'(level), 32'(lvl));
    chk({nm, " empty"}, 32'(empty), 32'(e));
    chk({nm, " full"}, 32'(full), 32'(f));
    chk({nm, " almost_empty"}, 32'(almost_empty), 32'(ae));
    chk({nm, " almost_full"}, 32'(almost_full), 32'(af));
  endtask

  initial begin
`ifdef PICO_FIFO_ERR_EN
    ovf_on = 1'b1;
`else
    ovf_on = 1'b0;
`endif
    //        fl aq sq din    lvl e f ae af dout  chk
    v[0]  = '{0, 1, 0, 8'hA1, 1, 0, 0, 1, 0, 8'hA1, 1};
    v[1]  = '{0, 1, 0, 8'hA2, 2, 0, 0, 0, 1, 8'hA1, 1};
    v[2]  = '{0, 1, 0, 8'hA3, 3, 0, 0, 0, 1, 8'hA1, 1};
    v[3]  = '{0, 1, 0, 8'hA4, 4, 0, 1, 0, 1, 8'hA1, 1};
    v[4]  = '{0, 1, 1, 8'hB5, 4, 0, 1, 0, 1, 8'hA2, 1};
    v[5]  = '{0, 0, 1, 8'h00, 3, 0, 0, 0, 1, 8'hA3, 1};
    v[6]  = '{0, 0, 1, 8'h00, 2, 0, 0, 0, 1, 8'hA4, 1};
    v[7]  = '{0, 0, 1, 8'h00, 1, 0, 0, 1, 0, 8'hB5, 1};
    v[8]  = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0};
    v[9]  = '{0, 1, 1, 8'h5A, 1, 0, 0, 1, 0, 8'h5A, 1};
    v[10] = '{0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 8'h00, 0};
    v[11] = '{0, 1, 0, 8'hC1, 1, 0, 0, 1, 0, 8'hC1, 1};
    v[12] = '{0, 1, 0, 8'hC2, 2, 0, 0, 0, 1, 8'hC1, 1};
    v[13] = '{0, 1, 0, 8'hC3, 3, 0, 0, 0, 1, 8'hC1, 1};
    v[14] = '{1, 1, 0, 8'hC4, 0, 1, 0, 1, 0, 8'h00, 0};

    repeat (2) @(posedge clk);
    #1;
    flags("reset", 0, 1, 0, 1, 0);
    chk("reset overflow", 32'(overflow), 0);
    chk("reset underflow", 32'(underflow), 0);
    @(negedge clk);
    reset = 1;

    for (int i = 0; i < 15; i++) begin
      op(v[i].fl, v[i].aq, v[i].sq, v[i].din, 0);
      flags($sformatf("vec%0d", i), v[i].lvl, v[i].e, v[i].f, v[i].ae, v[i].af);
      if (v[i].chk) chk($sformatf("vec%0d outdata", i), 32'(outdata), 32'(v[i].dout));
    end

    for (int i = 0; i < 4; i++) op(0, 1, 0, 8'hD1 + 8'(i), 0);
    op(0, 1, 0, 8'hCC, 0);
    flags("drop", 4, 0, 1, 0, 1);
    chk("drop outdata", 32'(outdata), 32'hD1);
    chk("drop overflow", 32'(overflow), 32'(ovf_on));
    op(0, 0, 0, 8'h00, 1);
    chk("clear overflow", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) begin
      op(0, 0, 1, 8'h00, 0);
      chk($sformatf("drain%0d outdata", i), 32'(outdata), 32'hD2 + 32'(i));
    end
    op(0, 0, 1, 8'h00, 0);
    flags("drained", 0, 1, 0, 1, 0);
    chk("drained underflow", 32'(underflow), 0);
    op(0, 0, 1, 8'h00, 0);
    chk("pop empty level", 32'(level), 0);
    chk("pop empty underflow", 32'(underflow), 32'(ovf_on));
    op(0, 0, 1, 8'h00, 1);
    chk("underflow wins clear", 32'(underflow), 32'(ovf_on));
    op(0, 0, 0, 8'h00, 1);
    chk("clear underflow", 32'(underflow), 0);

    for (int i = 0; i < 4; i++) op(0, 1, 0, 8'hE1 + 8'(i), 0);
    op(0, 1, 0, 8'hEE, 0);
    flags("prereset", 4, 0, 1, 0, 1);
    chk("prereset overflow", 32'(overflow), 32'(ovf_on));
    @(negedge clk);
    #2 reset = 0;
    #1;
    flags("async reset", 0, 1, 0, 1, 0);
    chk("async reset overflow", 32'(overflow), 0);
    chk("async reset underflow", 32'(underflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
